// File: rtl/ahb_lite_master.sv
// AHB-lite initiator: turns a single-beat valid/ready command stream into
// pipelined NONSEQ transfers, with one response per transfer and a stall watchdog.
module ahb_lite_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam int         CNT_W         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam bit         TIMEOUT_EN    = (TIMEOUT > 0);

  // Address-phase registers (driven straight onto the bus)
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic [ADDR_W-1:0] r_haddr;
  logic [DATA_W-1:0] r_ap_wdata;

  // Data-phase registers
  logic              r_dp_valid;
  logic              r_dp_write;
  logic [DATA_W-1:0] r_hwdata;

  // Response and watchdog registers
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_timeout_err;

  logic              w_busy;
  logic              w_ap_active;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_timeout_hit;

  assign w_ap_active = (r_htrans == HTRANS_NONSEQ);
  assign w_busy      = r_dp_valid | (r_htrans != HTRANS_IDLE);

  // Counter only runs while something is outstanding and the slave holds hready low
  always_comb begin
    w_cnt_next = r_stall_cnt;
    if (hready || !w_busy) begin
      w_cnt_next = '0;
    end else if (r_stall_cnt != CNT_MAX) begin
      w_cnt_next = r_stall_cnt + 1'b1;
    end
  end

  assign w_timeout_hit = TIMEOUT_EN && (w_cnt_next == CNT_MAX);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_htrans   <= HTRANS_IDLE;
      r_hwrite   <= 1'b0;
      r_haddr    <= '0;
      r_ap_wdata <= '0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_hwdata   <= '0;
    end else if (hready) begin
      r_dp_valid <= w_ap_active;
      r_dp_write <= r_hwrite;
      if (w_ap_active) begin
        r_hwdata <= r_ap_wdata;
      end
      if (cmd_valid) begin
        r_htrans   <= HTRANS_NONSEQ;
        r_haddr    <= cmd_addr;
        r_hwrite   <= cmd_write;
        r_ap_wdata <= cmd_wdata;
      end else begin
        r_htrans <= HTRANS_IDLE;
      end
    end
  end

  // Response fields keep their last value between pulses
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= hready & r_dp_valid;
      if (hready && r_dp_valid) begin
        r_rsp_write <= r_dp_write;
        r_rsp_rdata <= r_dp_write ? '0 : hrdata;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_stall_cnt <= w_cnt_next;
      if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign cmd_ready   = hready & ~hreset;
  assign htrans      = r_htrans;
  assign hwrite      = r_hwrite;
  assign haddr       = r_haddr;
  assign hwdata      = r_hwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_rsp_write;
  assign rsp_rdata   = r_rsp_rdata;
  assign busy        = w_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: directed vector table, hand-written
// pipeline/stall/timeout/reset sequences, and random traffic against a transfer-level model.
module tb_ahb_lite_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hready = 1'b1;
  logic [DW-1:0] hrdata = '0;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .hready      (hready),
    .hrdata      (hrdata),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change half a cycle before the edge; combinational outputs settle by +1.
  task automatic drive(input logic cv, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic hr, input logic [DW-1:0] hrd);
    @(negedge hclk);
    cmd_valid = cv;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    hready    = hr;
    hrdata    = hrd;
    #1;
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hclk);
      hreset    = 1'b1;
      cmd_valid = 1'b0;
      hready    = 1'b1;
      #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(negedge hclk);
    hreset = 1'b0;
  endtask

  typedef struct {
    logic          cv;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          hr;
    logic [DW-1:0] hrd;
    logic          e_rdy;
    logic [1:0]    e_trans;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [DW-1:0] e_wdata;
    logic          e_rv;
    logic          e_rw;
    logic [DW-1:0] e_rd;
    logic          e_busy;
  } vec_t;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            left;  // hready edges still needed before the transfer completes
  } xfer_t;

  vec_t  vt[13];
  xfer_t pipe[$];

  initial begin
    // Single write, single read, then a write/read pair with 3 wait states.
    vt[0]  = '{1'b1, 1'b1, 8'h0d, 32'h5a5a5a5a, 1'b1, 32'h0,        1'b1, 2'b10, 8'h0d, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 8'h0d, 1'b1, 32'h5a5a5a5a, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 8'h0d, 1'b1, 32'h5a5a5a5a, 1'b1, 1'b1, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 1'b0, 8'h0c, 32'h5a5a5a5a, 1'b1, 32'h0,        1'b1, 2'b10, 8'h0c, 1'b0, 32'h5a5a5a5a, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 8'h0c, 1'b0, 32'h5a5a5a5a, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 32'hcafe0001, 1'b1, 2'b00, 8'h0c, 1'b0, 32'h5a5a5a5a, 1'b1, 1'b0, 32'hcafe0001, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 8'h03, 32'h33,       1'b1, 32'h0,        1'b1, 2'b10, 8'h03, 1'b1, 32'h5a5a5a5a, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 1'b0, 8'h04, 32'h33,       1'b1, 32'h0,        1'b1, 2'b10, 8'h04, 1'b0, 32'h33,       1'b0, 1'b0, 32'h0,        1'b1};
    vt[8]  = '{1'b1, 1'b1, 8'h07, 32'h77,       1'b0, 32'h0,        1'b0, 2'b10, 8'h04, 1'b0, 32'h33,       1'b0, 1'b0, 32'h0,        1'b1};
    vt[9]  = vt[8];
    vt[10] = vt[8];
    vt[11] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 8'h04, 1'b0, 32'h33,       1'b1, 1'b1, 32'h0,        1'b1};
    vt[12] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 32'h44444444, 1'b1, 2'b00, 8'h04, 1'b0, 32'h33,       1'b1, 1'b0, 32'h44444444, 1'b0};

    // Reset values
    do_reset(5);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_haddr", 32'(haddr), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].cv, vt[i].w, vt[i].a, vt[i].d, vt[i].hr, vt[i].hrd);
      chk("vec_cmd_ready", 32'(cmd_ready), 32'(vt[i].e_rdy));
      tick();
      chk("vec_htrans", 32'(htrans), 32'(vt[i].e_trans));
      chk("vec_haddr", 32'(haddr), 32'(vt[i].e_addr));
      chk("vec_hwrite", 32'(hwrite), 32'(vt[i].e_write));
      chk("vec_hwdata", hwdata, vt[i].e_wdata);
      chk("vec_rsp_valid", 32'(rsp_valid), 32'(vt[i].e_rv));
      if (vt[i].e_rv) begin
        chk("vec_rsp_write", 32'(rsp_write), 32'(vt[i].e_rw));
        chk("vec_rsp_rdata", rsp_rdata, vt[i].e_rd);
      end
      chk("vec_busy", 32'(busy), 32'(vt[i].e_busy));
      chk("vec_timeout_err", 32'(timeout_err), 32'd0);
      $display("vec %0d: htrans=%0d haddr=%h hwdata=%h rsp_valid=%0b", i, htrans, haddr, hwdata, rsp_valid);
    end

    // Back-to-back: 10 writes with cmd_valid and hready held high
    begin
      int pulses = 0;
      int first_c = -1;
      int last_c = -1;
      for (int c = 0; c < 14; c++) begin
        if (c < 10) drive(1'b1, 1'b1, 8'(8'h99 - c), 32'(32'hfff - c), 1'b1, 32'h0);
        else drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 32'h0);
        tick();
        if (c < 10) begin
          chk("b2b_htrans", 32'(htrans), 32'd2);
          chk("b2b_haddr", 32'(haddr), 32'(8'h99 - c));
        end
        if (c >= 1 && c <= 10) chk("b2b_hwdata", hwdata, 32'(32'hfff - (c - 1)));
        if (rsp_valid) begin
          pulses++;
          if (first_c < 0) first_c = c;
          last_c = c;
          chk("b2b_rsp_write", 32'(rsp_write), 32'd1);
        end
      end
      chk("b2b_pulse_count", 32'(pulses), 32'd10);
      chk("b2b_pulse_span", 32'(last_c - first_c), 32'd9);
      $display("back-to-back: %0d responses, first at cycle %0d", pulses, first_c);
    end

    // Timeout: one write accepted, then the slave stalls for 4 edges
    drive(1'b1, 1'b1, 8'h55, 32'h1234, 1'b1, 32'h0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0);
      tick();
      chk("to_stall_err", 32'(timeout_err), (k == 4) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 32'h0);
      tick();
      chk("to_sticky_err", 32'(timeout_err), 32'd1);
    end
    do_reset(2);
    chk("to_cleared_by_reset", 32'(timeout_err), 32'd0);
    $display("timeout sequence done");

    // Random traffic against a transfer-level model: each accepted command needs
    // two further hready edges to complete, then responds one cycle later.
    begin
      int  stall_run = 0;
      bit  err_m = 0;
      int  nrsp = 0;
      for (int c = 0; c < 400; c++) begin
        logic          cv, w, hr, exp_rv, exp_rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d, hrd, exp_rd;
        cv  = ($urandom_range(0, 3) != 0);
        w   = 1'($urandom_range(0, 1));
        a   = 8'($urandom);
        d   = $urandom;
        hr  = ($urandom_range(0, 4) != 0);
        hrd = $urandom;
        drive(cv, w, a, d, hr, hrd);
        chk("rnd_cmd_ready", 32'(cmd_ready), 32'(hr));
        if (pipe.size() > 0 && pipe[pipe.size()-1].left == 2) begin
          chk("rnd_htrans", 32'(htrans), 32'd2);
          chk("rnd_haddr", 32'(haddr), 32'(pipe[pipe.size()-1].a));
          chk("rnd_hwrite", 32'(hwrite), 32'(pipe[pipe.size()-1].w));
        end else begin
          chk("rnd_htrans_idle", 32'(htrans), 32'd0);
        end
        if (pipe.size() > 0 && pipe[0].left == 1 && pipe[0].w) begin
          chk("rnd_hwdata", hwdata, pipe[0].d);
        end
        exp_rv = 1'b0;
        exp_rw = 1'b0;
        exp_rd = '0;
        if (hr) begin
          for (int k = 0; k < pipe.size(); k++) pipe[k].left = pipe[k].left - 1;
          if (pipe.size() > 0 && pipe[0].left == 0) begin
            exp_rv = 1'b1;
            exp_rw = pipe[0].w;
            exp_rd = pipe[0].w ? '0 : hrd;
            void'(pipe.pop_front());
          end
          if (cv) pipe.push_back('{w, a, d, 2});
          stall_run = 0;
        end else if (pipe.size() > 0) begin
          if (stall_run < TO) stall_run++;
          if (stall_run == TO) err_m = 1;
        end else begin
          stall_run = 0;
        end
        tick();
        chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
          chk("rnd_rsp_write", 32'(rsp_write), 32'(exp_rw));
          chk("rnd_rsp_rdata", rsp_rdata, exp_rd);
          nrsp++;
          $display("rnd rsp %0d: write=%0b rdata=%h", nrsp, rsp_write, rsp_rdata);
        end
        chk("rnd_busy", 32'(busy), 32'(pipe.size() != 0));
        chk("rnd_timeout_err", 32'(timeout_err), 32'(err_m));
      end
    end

    // Reset mid-operation drops outstanding transfers without a response
    drive(1'b1, 1'b1, 8'h21, 32'h2121, 1'b1, 32'h0);
    tick();
    drive(1'b1, 1'b0, 8'h22, 32'h0, 1'b1, 32'h0);
    tick();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    do_reset(1);
    pipe.delete();
    for (int k = 0; k < 3; k++) begin
      chk("midrst_htrans", 32'(htrans), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 32'h0);
      tick();
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    $display("mid-operation reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
